// File: rtl/serializador_pkg.sv
// Shared types and constants for the serializador byte-to-serial output stage.
package serializador_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam int   DATA_W      = 8;
   localparam logic SERIAL_IDLE = 1'b1;

endpackage

// File: rtl/ser_shift_reg.sv
// Load/shift register with bit counter. Holds the frame bits still to be sent
// after the one currently on the line; bit_nxt is the bit to present next.
import serializador_pkg::*;

module ser_shift_reg #(
   parameter int FRAME_W = DATA_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               shift,
   input  logic [FRAME_W-2:0] data,
   output logic               bit_nxt,
   output logic               last
);

   localparam int CNT_W = $clog2(FRAME_W);

   logic [FRAME_W-2:0] sr;
   logic [CNT_W-1:0]   cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load) begin
         sr  <= data;
         cnt <= '0;
      end else if (shift) begin
         sr  <= {sr[FRAME_W-3:0], 1'b0};
         cnt <= cnt + 1'b1;
      end
   end

   assign bit_nxt = sr[FRAME_W-2];
   assign last    = (cnt == CNT_W'(FRAME_W - 1));

endmodule

// File: rtl/serializador.sv
// serializador: pops bytes from the queue and sends them MSB-first under a
// ready handshake. SERIALIZADOR_PARITY_EN appends an even parity bit.
import serializador_pkg::*;

module serializador #(
   parameter int DATA_W     = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic              clk_100KHz,
   input  logic              reset,
   input  logic [7:0]        len_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic              ready_in,
   output logic              dequeue_out,
   output logic              serial_out,
   output logic              valid_out,
   output logic              busy_out,
   output logic              frame_done_out
);

`ifdef SERIALIZADOR_PARITY_EN
   localparam int FRAME_W = DATA_W + 1;
`else
   localparam int FRAME_W = DATA_W;
`endif
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   state_t             state, state_nxt;
   logic [GAP_W-1:0]   gap_cnt, gap_nxt;
   logic               deq_nxt, ser_nxt, vld_nxt, done_nxt;
   logic               load, shift, bit_nxt, last;
   logic [FRAME_W-1:0] frame;

`ifdef SERIALIZADOR_PARITY_EN
   assign frame = {data_in, ^data_in};
`else
   assign frame = data_in;
`endif

   ser_shift_reg #(.FRAME_W(FRAME_W)) u_shift (
      .clk     (clk_100KHz),
      .reset   (reset),
      .load    (load),
      .shift   (shift),
      .data    (frame[FRAME_W-2:0]),
      .bit_nxt (bit_nxt),
      .last    (last)
   );

   always_ff @(posedge clk_100KHz) begin
      if (reset) begin
         state          <= IDLE;
         gap_cnt        <= '0;
         dequeue_out    <= 1'b0;
         serial_out     <= SERIAL_IDLE;
         valid_out      <= 1'b0;
         busy_out       <= 1'b0;
         frame_done_out <= 1'b0;
      end else begin
         state          <= state_nxt;
         gap_cnt        <= gap_nxt;
         dequeue_out    <= deq_nxt;
         serial_out     <= ser_nxt;
         valid_out      <= vld_nxt;
         busy_out       <= (state_nxt != IDLE);
         frame_done_out <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gap_nxt   = gap_cnt;
      deq_nxt   = 1'b0;
      ser_nxt   = serial_out;
      vld_nxt   = valid_out;
      done_nxt  = 1'b0;
      load      = 1'b0;
      shift     = 1'b0;
      case (state)
         IDLE: begin
            ser_nxt = SERIAL_IDLE;
            vld_nxt = 1'b0;
            // The frame_done cycle doubles as the IDLE re-evaluation slot when there is no gap.
            if (len_in != '0 && ready_in && !frame_done_out) begin
               load      = 1'b1;
               deq_nxt   = 1'b1;
               ser_nxt   = frame[FRAME_W-1];
               vld_nxt   = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (ready_in) begin
               if (last) begin
                  vld_nxt   = 1'b0;
                  ser_nxt   = SERIAL_IDLE;
                  done_nxt  = 1'b1;
                  gap_nxt   = '0;
                  state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
               end else begin
                  shift   = 1'b1;
                  ser_nxt = bit_nxt;
               end
            end
         end
         GAP: begin
            if (int'(gap_cnt) >= GAP_CYCLES - 1) state_nxt = IDLE;
            else gap_nxt = gap_cnt + 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_serializador.sv
// Directed bench for serializador: reset, single frame, stall, empty queue,
// mid-frame reset, back-to-back frames and (when enabled) parity.
module tb_serializador;

   localparam int GAP = 2;
`ifdef SERIALIZADOR_PARITY_EN
   localparam int FRAME = 9;
`else
   localparam int FRAME = 8;
`endif
   localparam int PERIOD = FRAME + 1 + GAP;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] len = 8'd0;
   logic [7:0] data = 8'd0;
   logic       ready = 1'b0;
   logic       dequeue, serial, valid, busy, done;
   int         total = 0;
   int         bad = 0;

   serializador #(.DATA_W(8), .GAP_CYCLES(GAP)) dut (
      .clk_100KHz     (clk),
      .reset          (reset),
      .len_in         (len),
      .data_in        (data),
      .ready_in       (ready),
      .dequeue_out    (dequeue),
      .serial_out     (serial),
      .valid_out      (valid),
      .busy_out       (busy),
      .frame_done_out (done)
   );

   always #5 clk = ~clk;

   function automatic logic exp_bit(input logic [7:0] d, input int i);
      if (i < 8) return d[7-i];
      return ^d;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle;
      int n = 0;
      while ((busy !== 1'b0 || done !== 1'b0) && n < 40) begin
         tick;
         n++;
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_timeout busy=%b want 0", busy);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; len = 8'd0; ready = 1'b0;
      tick; tick;
      total++;
      if ({dequeue, serial, valid, busy, done} !== 5'b01000) begin
         bad++;
         $display("FAIL reset_outputs deq/ser/vld/busy/done=%b want 01000",
                  {dequeue, serial, valid, busy, done});
      end
      reset = 1'b0;
      tick;
      total++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle busy=%b valid=%b want 0 0", busy, valid);
      end
   endtask

   task automatic test_frame_a5;
      int deq = 0;
      len = 8'd1; data = 8'hA5; ready = 1'b1;
      tick;
      len = 8'd0;
      total++;
      if (busy !== 1'b1 || dequeue !== 1'b1) begin
         bad++;
         $display("FAIL a5_start busy=%b dequeue=%b want 1 1", busy, dequeue);
      end
      for (int i = 0; i < FRAME; i++) begin
         total++;
         if (valid !== 1'b1 || serial !== exp_bit(8'hA5, i) || done !== 1'b0) begin
            bad++;
            $display("FAIL a5_bit%0d serial=%b valid=%b done=%b want %b 1 0",
                     i, serial, valid, done, exp_bit(8'hA5, i));
         end
         if (dequeue === 1'b1) deq++;
         tick;
      end
      total++;
      if (done !== 1'b1 || valid !== 1'b0 || serial !== 1'b1) begin
         bad++;
         $display("FAIL a5_done done=%b valid=%b serial=%b want 1 0 1", done, valid, serial);
      end
      total++;
      if (deq !== 1) begin
         bad++;
         $display("FAIL a5_dequeue_count got=%0d want 1", deq);
      end
      tick;
      total++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL a5_gap done=%b busy=%b want 0 1", done, busy);
      end
      tick;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL a5_idle busy=%b want 0", busy);
      end
   endtask

   task automatic test_stall;
      len = 8'd1; data = 8'h3C; ready = 1'b1;
      tick;
      len = 8'd0;
      for (int j = 0; j < FRAME; j++) begin
         total++;
         if (valid !== 1'b1 || serial !== exp_bit(8'h3C, j)) begin
            bad++;
            $display("FAIL stall_bit%0d serial=%b valid=%b want %b 1",
                     j, serial, valid, exp_bit(8'h3C, j));
         end
         if (j == 3) begin
            ready = 1'b0;
            repeat (3) begin
               tick;
               total++;
               if (valid !== 1'b1 || serial !== exp_bit(8'h3C, 3) || done !== 1'b0) begin
                  bad++;
                  $display("FAIL stall_hold serial=%b valid=%b done=%b want %b 1 0",
                           serial, valid, done, exp_bit(8'h3C, 3));
               end
            end
            ready = 1'b1;
         end
         tick;
      end
      total++;
      if (done !== 1'b1 || valid !== 1'b0) begin
         bad++;
         $display("FAIL stall_done done=%b valid=%b want 1 0", done, valid);
      end
      wait_idle;
   endtask

   task automatic test_empty;
      len = 8'd0; data = 8'hFF; ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick;
         total++;
         if (dequeue !== 1'b0 || valid !== 1'b0 || serial !== 1'b1) begin
            bad++;
            $display("FAIL empty_cycle%0d dequeue=%b valid=%b serial=%b want 0 0 1",
                     i, dequeue, valid, serial);
         end
      end
   endtask

   task automatic test_reset_mid;
      len = 8'd1; data = 8'hA5; ready = 1'b1;
      tick;
      len = 8'd0;
      repeat (4) tick;
      total++;
      if (valid !== 1'b1 || serial !== exp_bit(8'hA5, 4)) begin
         bad++;
         $display("FAIL midrst_bit4 serial=%b valid=%b want %b 1", serial, valid, exp_bit(8'hA5, 4));
      end
      reset = 1'b1;
      tick;
      reset = 1'b0;
      total++;
      if ({dequeue, serial, valid, busy, done} !== 5'b01000) begin
         bad++;
         $display("FAIL midrst_outputs deq/ser/vld/busy/done=%b want 01000",
                  {dequeue, serial, valid, busy, done});
      end
      repeat (2) begin
         tick;
         total++;
         if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_quiet done=%b valid=%b busy=%b want 0 0 0", done, valid, busy);
         end
      end
      len = 8'd1; data = 8'hC3;
      tick;
      len = 8'd0;
      total++;
      if (dequeue !== 1'b1) begin
         bad++;
         $display("FAIL midrst_restart dequeue=%b want 1", dequeue);
      end
      for (int i = 0; i < FRAME; i++) begin
         total++;
         if (valid !== 1'b1 || serial !== exp_bit(8'hC3, i)) begin
            bad++;
            $display("FAIL midrst_c3_bit%0d serial=%b valid=%b want %b 1",
                     i, serial, valid, exp_bit(8'hC3, i));
         end
         tick;
      end
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL midrst_c3_done done=%b want 1", done);
      end
      wait_idle;
   endtask

   task automatic test_back_to_back;
      logic [7:0] q [3] = '{8'h11, 8'h5A, 8'hF0};
      int head = 0, deq = 0, last = -1, nbits = 0;
      logic e;
      len = 8'd3; data = q[0]; ready = 1'b1;
      for (int cyc = 0; cyc < 3 * PERIOD + 10; cyc++) begin
         tick;
         if (valid === 1'b1) begin
            if (nbits < 3 * FRAME) begin
               e = exp_bit(q[nbits / FRAME], nbits % FRAME);
               total++;
               if (serial !== e) begin
                  bad++;
                  $display("FAIL b2b_bit%0d serial=%b want %b", nbits, serial, e);
               end
            end
            nbits++;
         end
         if (dequeue === 1'b1) begin
            deq++;
            total++;
            if (len == 8'd0) begin
               bad++;
               $display("FAIL b2b_deq_empty dequeue=1 with len=0 want no pop");
            end
            if (last >= 0) begin
               total++;
               if (cyc - last != PERIOD) begin
                  bad++;
                  $display("FAIL b2b_period got=%0d want %0d", cyc - last, PERIOD);
               end
            end
            last = cyc;
            head++;
            if (len != 8'd0) len = len - 8'd1;
            data = (head < 3) ? q[head] : 8'h00;
         end
      end
      total++;
      if (deq != 3 || nbits != 3 * FRAME) begin
         bad++;
         $display("FAIL b2b_counts dequeues=%0d bits=%0d want 3 %0d", deq, nbits, 3 * FRAME);
      end
      wait_idle;
   endtask

`ifdef SERIALIZADOR_PARITY_EN
   task automatic test_parity;
      logic [7:0] b [2] = '{8'h07, 8'h03};
      logic       p [2] = '{1'b1, 1'b0};
      for (int k = 0; k < 2; k++) begin
         len = 8'd1; data = b[k]; ready = 1'b1;
         tick;
         len = 8'd0;
         repeat (8) tick;
         total++;
         if (valid !== 1'b1 || serial !== p[k]) begin
            bad++;
            $display("FAIL parity_%h serial=%b valid=%b want %b 1", b[k], serial, valid, p[k]);
         end
         tick;
         total++;
         if (done !== 1'b1) begin
            bad++;
            $display("FAIL parity_%h_done done=%b want 1", b[k], done);
         end
         wait_idle;
      end
   endtask
`endif

   initial begin
      test_reset;
      test_frame_a5;
      test_stall;
      test_empty;
      test_reset_mid;
      test_back_to_back;
`ifdef SERIALIZADOR_PARITY_EN
      test_parity;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serializador.md
# serializador

Parallel-to-serial output stage sitting directly downstream of the byte queue (`fila`): whenever the queue holds data and the downstream sink is ready, it pops one byte, then shifts it out MSB-first, one bit per accepted handshake. It is followed by an optional parity bit and a configurable idle gap. It is the counterpart of the deserializer and completes the byte path: serial in → queue → serial out.

## Interface
- `DATA_W`, 8: byte width; fixed at 8 for this design, bit counter sized from it.
- `GAP_CYCLES`, 2: idle cycles after each frame; 0 is legal.
- `clk_100KHz`  input  1  single clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high; sampled on `clk_100KHz`.
- `len_in`  input  8  current queue occupancy.
- `data_in`  input  8  queue head entry; valid whenever `len_in != 0`.
- `ready_in`  input  1  downstream sink can accept a bit this cycle.
- `dequeue_out`  output  1  one-cycle pop pulse to the queue.
- `serial_out`  output  1  current bit; idles high.
- `valid_out`  output  1  `serial_out` carries a frame bit.
- `busy_out`  output  1  high in every state except IDLE.
- `frame_done_out`  output  1  one-cycle pulse when the last bit of a frame is accepted.

## Operation
- All outputs are registered. Reset values:
  - `dequeue_out`=0, `serial_out`=1, `valid_out`=0, `busy_out`=0, `frame_done_out`=0.
  - State=IDLE; shift register and counters cleared.
- FSM states are IDLE, SEND, GAP.
- IDLE: on an edge with `len_in != 0` and `ready_in`=1, in the same edge:
  - capture `data_in` into the shift register;
  - set `dequeue_out`=1 for exactly one cycle;
  - set `serial_out`=`data_in[7]` and `valid_out`=1;
  - go to SEND.
  - Otherwise remain in IDLE.
- SEND: a bit is accepted on an edge where `valid_out`=1 and `ready_in`=1.
  - On acceptance, advance to the next bit (MSB→LSB).
  - When `ready_in`=0, hold `serial_out` and the counter unchanged (stall, no limit).
- After data bit 0 is accepted (or the parity bit, when enabled):
  - set `valid_out`=0, `serial_out`=1, `frame_done_out`=1 for one cycle;
  - go to GAP, or directly to IDLE when `GAP_CYCLES`=0.
- GAP: count `GAP_CYCLES` edges, then go to IDLE; `len_in` is ignored during GAP.
- `dequeue_out` is never asserted when `len_in`=0 and never twice per frame.
- Reset mid-frame: return to IDLE on the next edge. The in-flight byte is discarded (it has already been popped); no `frame_done_out` pulse is produced.
- A `len_in` change during SEND or GAP has no effect. Occupancy is rechecked only in IDLE.

## Timing
- Detect edge E: `dequeue_out`, `valid_out` and the first bit are visible in cycle E+1.
- With `ready_in` held high, the data bits are accepted on edges E+1..E+8; `frame_done_out` is high in cycle E+9.
- Back-to-back byte period with `ready_in` high:
  - 9+`GAP_CYCLES` cycles, or 10+`GAP_CYCLES` cycles with parity;
  - plus 1 cycle when `GAP_CYCLES`=0 (IDLE re-evaluation).
- Each `ready_in` low cycle during SEND adds exactly one cycle.
- `busy_out` rises with `dequeue_out` and falls on the cycle the state returns to IDLE.

## Configuration
- `SERIALIZADOR_PARITY_EN` defined:
  - a 9th bit, the even parity (XOR of the 8 captured data bits), is sent after bit 0 under the same handshake;
  - `frame_done_out` fires on its acceptance.
- Undefined: frames are exactly 8 bits and there is no parity logic.

## Structure
- Shared package `serializador_pkg`:
  - state enum typedef (IDLE, SEND, GAP);
  - `DATA_W` localparam;
  - `SERIAL_IDLE`=1'b1 constant.
- One natural sub-module, `ser_shift_reg`: load/shift register with bit counter, exposing the current bit and a last-bit flag. The FSM and gap counter stay in the top module.

## Test plan
- Reset, then `len_in`=1, `data_in`=8'hA5, `ready_in`=1:
  - one `dequeue_out` pulse;
  - `serial_out` sequence 1,0,1,0,0,1,0,1 on consecutive valid cycles;
  - `frame_done_out` at E+9.
- `ready_in` dropped for 3 cycles after bit 2 of 8'h3C → bits held stable, frame completes 3 cycles later, no lost or duplicated bits.
- `len_in`=0 for 20 cycles → no `dequeue_out`, `valid_out`=0, `serial_out`=1 throughout.
- `len_in`=3 with `GAP_CYCLES`=2 → three frames at an 11-cycle period, exactly three `dequeue_out` pulses.
- `reset` asserted at bit 4 → all outputs return to reset values on the next edge; the next frame starts cleanly from IDLE.
- With `SERIALIZADOR_PARITY_EN`, byte 8'h07 → 9th bit = 1; byte 8'h03 → 9th bit = 0.
